// File: rtl/rpn_entry_pkg.sv
// ============================================================================
//  Module   : rpn_entry_pkg
//  Purpose  : Switch-code constants, FSM states and code classification for
//             the RPN calculator entry path and its control unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rpn_entry_pkg;

    localparam logic [3:0] CODE_ADD       = 4'hA;
    localparam logic [3:0] CODE_SUB       = 4'hB;
    localparam logic [3:0] CODE_AND       = 4'hC;
    localparam logic [3:0] CODE_OR        = 4'hD;
    localparam logic [3:0] CODE_DROP      = 4'hE;
    localparam logic [3:0] CODE_INVALID   = 4'hF;
    localparam logic [3:0] CODE_MAX_DIGIT = 4'h9;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_OPERAND  = 2'd0,
        CLS_OPERATOR = 2'd1,
        CLS_INVALID  = 2'd2
    } code_class_e;

    function automatic code_class_e classify_code(input logic [3:0] code);
        code_class_e cls;
        cls = CLS_INVALID;
        if (code <= CODE_MAX_DIGIT) begin
            cls = CLS_OPERAND;
        end else if (code != CODE_INVALID) begin
            case (code)
                CODE_ADD, CODE_SUB, CODE_AND, CODE_OR, CODE_DROP: cls = CLS_OPERATOR;
                default:                                          cls = CLS_INVALID;
            endcase
        end
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
//  Module   : key_debouncer
//  Purpose  : Two-flop synchroniser and counter debouncer for the active-low
//             enter key; emits a one-cycle pulse on each debounced press.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o,
    output logic key_stable_o
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_meta_q;
    logic             key_sync_q;
    logic             key_stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Level is accepted only after it has disagreed with the stable value
    // for DEBOUNCE_CYCLES+1 consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q   <= 1'b1;
            key_sync_q   <= 1'b1;
            key_stable_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            key_meta_q <= key_n_i;
            key_sync_q <= key_meta_q;
            press_q    <= 1'b0;
            if (key_sync_q == key_stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                key_stable_q <= key_sync_q;
                cnt_q        <= '0;
                press_q      <= ~key_sync_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o      = press_q;
    assign key_stable_o = key_stable_q;

endmodule

`default_nettype wire

// File: rtl/rpn_entry_encoder.sv
// ============================================================================
//  Module   : rpn_entry_encoder
//  Purpose  : Key/switch front-end for the RPN calculator; turns each debounced
//             press into one operand/operator token on a valid/ready handshake.
//             Optional auto-repeat while the key is held: ENTRY_AUTOREPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_entry_encoder
    import rpn_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    input  logic       key_n,
    input  logic       tok_ready,
    output logic       tok_valid,
    output logic       tok_is_op,
    output logic [7:0] tok_data,
    output logic       err,
    output logic       busy
);

    logic [3:0]  sw_meta_q;
    logic [3:0]  sw_sync_q;
    logic        w_press;
    logic        w_key_stable;
    logic        w_rep_fire;
    logic        w_any_press;
    code_class_e w_cls;

    state_e      state_q, state_d;
    logic [3:0]  data_q, data_d;
    logic        is_op_q, is_op_d;
    logic        err_q, err_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk          (clk),
        .rst          (rst),
        .key_n_i      (key_n),
        .press_o      (w_press),
        .key_stable_o (w_key_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= 4'h0;
            sw_sync_q <= 4'h0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

`ifdef ENTRY_AUTOREPEAT_EN
    localparam int              REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             w_rep_run;

    // Counts only while idle with the key held; any press restarts the interval.
    assign w_rep_run  = (state_q == ST_IDLE) && !w_key_stable;
    assign w_rep_fire = w_rep_run && (rep_q == REP_LAST);

    always_comb begin
        rep_d = rep_q + 1'b1;
        if (!w_rep_run || w_press || w_rep_fire) begin
            rep_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    // No repeat hardware; the parameter only keeps the interface uniform.
    assign w_rep_fire = 1'b0 && (REPEAT_CYCLES > 0);
`endif

    assign w_any_press = w_press || w_rep_fire;
    assign w_cls       = classify_code(sw_sync_q);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        is_op_d = is_op_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_any_press) begin
                    if (w_cls == CLS_INVALID) begin
                        err_d = 1'b1;
                    end else begin
                        data_d  = sw_sync_q;
                        is_op_d = (w_cls == CLS_OPERATOR);
                        state_d = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                // A physical press cannot be queued behind a pending token.
                if (w_press) begin
                    err_d = 1'b1;
                end
                if (tok_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= 4'h0;
            is_op_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            is_op_q <= is_op_d;
            err_q   <= err_d;
        end
    end

    assign tok_valid = (state_q == ST_VALID);
    assign busy      = (state_q == ST_VALID);
    assign tok_is_op = is_op_q;
    assign tok_data  = {4'h0, data_q};
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rpn_entry_encoder.sv
// ============================================================================
//  Module   : tb_rpn_entry_encoder
//  Purpose  : Directed plus random stimulus for rpn_entry_encoder, compared
//             each cycle against a queue-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpn_entry_encoder;

    localparam int DEB = 4;
    localparam int REP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic       key_n;
    logic       tok_ready;
    logic       tok_valid;
    logic       tok_is_op;
    logic [7:0] tok_data;
    logic       err;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rpn_entry_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .key_n     (key_n),
        .tok_ready (tok_ready),
        .tok_valid (tok_valid),
        .tok_is_op (tok_is_op),
        .tok_data  (tok_data),
        .err       (err),
        .busy      (busy)
    );

    // Reference model: synchronisers as 2-deep delay queues, debounce as
    // "the last DEB+1 synchronised samples all disagree with the stable level".
    bit       kp[$];
    bit [3:0] sp[$];
    bit       hist[$];
    bit       m_stable;
    bit       m_press;
    bit       m_valid;
    bit [3:0] m_data;
    bit       m_isop;
    bit       m_err;
    int       m_run;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit k, input bit [3:0] s, input bit rdy);
        bit       ksy;
        bit [3:0] ssy;
        bit       fire;
        bit       pr;
        bit       flip;
        bit       idle_low;
        int       c;
        if (r) begin
            kp = '{1'b1, 1'b1};
            sp = '{4'h0, 4'h0};
            hist.delete();
            m_stable = 1'b1;
            m_press  = 1'b0;
            m_valid  = 1'b0;
            m_data   = 4'h0;
            m_isop   = 1'b0;
            m_err    = 1'b0;
            m_run    = 0;
            return;
        end
        ksy      = kp[0];
        ssy      = sp[0];
        idle_low = !m_valid && !m_stable;
        c        = m_run + 1;
        fire     = 1'b0;
`ifdef ENTRY_AUTOREPEAT_EN
        fire = idle_low && (c == REP);
`endif
        pr = m_press || fire;
        m_run = (!idle_low || pr) ? 0 : c;

        m_err = 1'b0;
        if (!m_valid) begin
            if (pr) begin
                if (ssy == 4'hF) begin
                    m_err = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_data  = ssy;
                    m_isop  = (ssy > 4'h9);
                end
            end
        end else begin
            if (m_press) m_err = 1'b1;
            if (rdy)     m_valid = 1'b0;
        end

        hist.push_back(ksy);
        if (hist.size() > DEB + 1) void'(hist.pop_front());
        m_press = 1'b0;
        if (hist.size() == DEB + 1) begin
            flip = 1'b1;
            foreach (hist[i]) if (hist[i] == m_stable) flip = 1'b0;
            if (flip) begin
                m_stable = ~m_stable;
                m_press  = !m_stable;
                hist.delete();
            end
        end

        void'(kp.pop_front());
        kp.push_back(k);
        void'(sp.pop_front());
        sp.push_back(s);
    endtask

    task automatic step(input bit r, input bit k, input bit [3:0] s, input bit rdy);
        @(negedge clk);
        check_val("tok_valid", tok_valid, m_valid);
        check_val("busy",      busy,      m_valid);
        check_val("err",       err,       m_err);
        check_val("tok_is_op", tok_is_op, m_isop);
        check_val("tok_data",  tok_data,  {4'h0, m_data});
        rst       = r;
        key_n     = k;
        sw_in     = s;
        tok_ready = rdy;
        model_edge(r, k, s, rdy);
    endtask

    task automatic hold(input int n, input bit k, input bit [3:0] s, input bit rdy);
        repeat (n) step(1'b0, k, s, rdy);
    endtask

    initial begin
        int       len;
        bit       rk;
        bit [3:0] rs;
        bit       rr;
        bit       rrdy;

        rst       = 1'b1;
        key_n     = 1'b1;
        sw_in     = 4'h0;
        tok_ready = 1'b0;
        model_edge(1'b1, 1'b1, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b0);

        // operand press, ready held high
        hold(10, 1'b0, 4'h7, 1'b1);
        hold(10, 1'b1, 4'h7, 1'b1);

        // bounce then a clean operator press under backpressure
        for (int i = 0; i < 5; i++) begin
            hold(2, 1'b0, 4'hB, 1'b0);
            hold(2, 1'b1, 4'hB, 1'b0);
        end
        hold(10, 1'b0, 4'hB, 1'b0);
        hold(6,  1'b1, 4'hB, 1'b0);
        hold(8,  1'b0, 4'h3, 1'b0);
        hold(6,  1'b1, 4'h3, 1'b0);
        hold(3,  1'b1, 4'h3, 1'b1);

        // invalid code
        hold(10, 1'b0, 4'hF, 1'b1);
        hold(10, 1'b1, 4'hF, 1'b1);

        // reset while a token is pending, key held through it
        hold(12, 1'b0, 4'h5, 1'b0);
        step(1'b1, 1'b0, 4'h5, 1'b0);
        hold(12, 1'b0, 4'h5, 1'b1);
        hold(8,  1'b1, 4'h5, 1'b1);

        // long hold (repeat tokens only in the auto-repeat build)
        hold(40, 1'b0, 4'h2, 1'b1);
        hold(10, 1'b1, 4'h2, 1'b1);

        // random segments of key levels, switch codes, ready and rare resets
        repeat (150) begin
            len = $urandom_range(1, 25);
            rk  = 1'($urandom);
            rs  = 4'($urandom);
            for (int i = 0; i < len; i++) begin
                rr   = ($urandom_range(0, 299) == 0);
                rrdy = (($urandom % 4) != 0);
                if (($urandom % 8) == 0) rs = 4'($urandom);
                step(rr, rk, rs, rrdy);
            end
        end
        step(1'b0, 1'b1, 4'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
